// File: rtl/valid_ctrl_pkg.sv
// Shared encodings for the valid-array controller: FSM states and arbiter grant sources.
package valid_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_INV    = 2'd1,
    GNT_FILL   = 2'd2,
    GNT_LOOKUP = 2'd3
  } grant_e;

endpackage

// File: rtl/valid_array_sweep_counter.sv
// Set pointer for the clear-all sweep: advances when enabled, wraps after the last set.
module valid_array_sweep_counter #(
  parameter int unsigned NUMBER_SETS           = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_en,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0] o_set,
  output logic                             o_last
);

  localparam int unsigned SW = SET_PTR_WIDTH_IN_BITS;
  localparam logic [SW-1:0] LAST_SET = SW'(NUMBER_SETS - 1);

  logic [SW-1:0] r_set;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_set <= '0;
    end else if (i_en) begin
      r_set <= (r_set == LAST_SET) ? '0 : r_set + SW'(1);
    end
  end

  assign o_set  = r_set;
  assign o_last = i_en && (r_set == LAST_SET);

endmodule

// File: rtl/valid_array_ctrl.sv
// Sweep sequencer and invalidate > fill > lookup arbiter for a per-set valid-bit array.
module valid_array_ctrl
  import valid_ctrl_pkg::*;
#(
  parameter int unsigned NUMBER_SETS           = 64,
  parameter int unsigned NUMBER_WAYS           = 16,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS)
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             flush_req_in,
  output logic                             flush_done_out,
  output logic                             init_busy_out,
  input  logic                             inv_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] inv_set_in,
  input  logic [NUMBER_WAYS-1:0]           inv_way_in,
  output logic                             inv_ready_out,
  input  logic                             fill_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] fill_set_in,
  input  logic [NUMBER_WAYS-1:0]           fill_way_in,
  output logic                             fill_ready_out,
  input  logic                             lookup_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] lookup_set_in,
  output logic                             lookup_ready_out,
  output logic                             lookup_resp_valid_out,
  output logic [NUMBER_WAYS-1:0]           lookup_resp_bits_out,
  output logic                             array_access_en_out,
  output logic                             array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0] array_set_addr_out,
  output logic [NUMBER_WAYS-1:0]           array_way_select_out,
  output logic [NUMBER_WAYS-1:0]           array_write_bits_out,
  input  logic [NUMBER_WAYS-1:0]           array_read_bits_in
);

  localparam int unsigned SW = SET_PTR_WIDTH_IN_BITS;

  state_e        r_state;
  state_e        w_state_next;
  grant_e        w_grant;
  logic          w_sweep_en;
  logic          w_sweep_last;
  logic [SW-1:0] w_sweep_set;
  logic          r_resp_valid;

  valid_array_sweep_counter #(
    .NUMBER_SETS          (NUMBER_SETS),
    .SET_PTR_WIDTH_IN_BITS(SW)
  ) u_sweep_counter (
    .i_clk  (clk_in),
    .i_rst_n(reset_in),
    .i_en   (w_sweep_en),
    .o_set  (w_sweep_set),
    .o_last (w_sweep_last)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush requests seen while sweeping are absorbed: only RUN looks at them.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT, ST_FLUSH: if (w_sweep_last) w_state_next = ST_RUN;
      ST_RUN:            if (flush_req_in) w_state_next = ST_FLUSH;
      default:           w_state_next = ST_INIT;
    endcase
  end

  // Sweep strobes are gated by reset so the array sees nothing while reset is held.
  always_comb begin
    w_grant              = GNT_NONE;
    w_sweep_en           = 1'b0;
    flush_done_out       = 1'b0;
    init_busy_out        = (r_state != ST_RUN);
    inv_ready_out        = 1'b0;
    fill_ready_out       = 1'b0;
    lookup_ready_out     = 1'b0;
    array_access_en_out  = 1'b0;
    array_write_en_out   = 1'b0;
    array_set_addr_out   = '0;
    array_way_select_out = '0;
    array_write_bits_out = '0;
    case (r_state)
      ST_INIT, ST_FLUSH: begin
        w_sweep_en           = reset_in;
        flush_done_out       = w_sweep_last;
        array_access_en_out  = reset_in;
        array_write_en_out   = reset_in;
        array_set_addr_out   = w_sweep_set;
        array_way_select_out = '1;
      end
      ST_RUN: begin
        if (!flush_req_in) begin
          if (inv_valid_in) begin
            w_grant              = GNT_INV;
            inv_ready_out        = 1'b1;
            array_access_en_out  = 1'b1;
            array_write_en_out   = 1'b1;
            array_set_addr_out   = inv_set_in;
            array_way_select_out = inv_way_in;
          end else if (fill_valid_in) begin
            w_grant              = GNT_FILL;
            fill_ready_out       = 1'b1;
            array_access_en_out  = 1'b1;
            array_write_en_out   = 1'b1;
            array_set_addr_out   = fill_set_in;
            array_way_select_out = fill_way_in;
            array_write_bits_out = '1;
          end else if (lookup_valid_in) begin
            w_grant             = GNT_LOOKUP;
            lookup_ready_out    = 1'b1;
            array_access_en_out = 1'b1;
            array_set_addr_out  = lookup_set_in;
          end
        end
      end
      default: ;
    endcase
  end

  // Response tracks the grant independently of state, so a flush cannot cancel it.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_resp_valid <= 1'b0;
    end else begin
      r_resp_valid <= (w_grant == GNT_LOOKUP);
    end
  end

  assign lookup_resp_valid_out = r_resp_valid;
  assign lookup_resp_bits_out  = r_resp_valid ? array_read_bits_in : '0;

endmodule

// File: tb/tb_valid_array_ctrl.sv
// Directed bench for valid_array_ctrl with a behavioural valid array and a lookup-response scoreboard.
module tb_valid_array_ctrl;

  localparam int unsigned NS = 4;
  localparam int unsigned NW = 4;
  localparam int unsigned SW = 2;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic          flush_req_in;
  logic          flush_done_out;
  logic          init_busy_out;
  logic          inv_valid_in;
  logic [SW-1:0] inv_set_in;
  logic [NW-1:0] inv_way_in;
  logic          inv_ready_out;
  logic          fill_valid_in;
  logic [SW-1:0] fill_set_in;
  logic [NW-1:0] fill_way_in;
  logic          fill_ready_out;
  logic          lookup_valid_in;
  logic [SW-1:0] lookup_set_in;
  logic          lookup_ready_out;
  logic          lookup_resp_valid_out;
  logic [NW-1:0] lookup_resp_bits_out;
  logic          array_access_en_out;
  logic          array_write_en_out;
  logic [SW-1:0] array_set_addr_out;
  logic [NW-1:0] array_way_select_out;
  logic [NW-1:0] array_write_bits_out;
  logic [NW-1:0] array_read_bits_in;

  always #5 clk_in = ~clk_in;

  valid_array_ctrl #(
    .NUMBER_SETS          (NS),
    .NUMBER_WAYS          (NW),
    .SET_PTR_WIDTH_IN_BITS(SW)
  ) dut (
    .clk_in               (clk_in),
    .reset_in             (reset_in),
    .flush_req_in         (flush_req_in),
    .flush_done_out       (flush_done_out),
    .init_busy_out        (init_busy_out),
    .inv_valid_in         (inv_valid_in),
    .inv_set_in           (inv_set_in),
    .inv_way_in           (inv_way_in),
    .inv_ready_out        (inv_ready_out),
    .fill_valid_in        (fill_valid_in),
    .fill_set_in          (fill_set_in),
    .fill_way_in          (fill_way_in),
    .fill_ready_out       (fill_ready_out),
    .lookup_valid_in      (lookup_valid_in),
    .lookup_set_in        (lookup_set_in),
    .lookup_ready_out     (lookup_ready_out),
    .lookup_resp_valid_out(lookup_resp_valid_out),
    .lookup_resp_bits_out (lookup_resp_bits_out),
    .array_access_en_out  (array_access_en_out),
    .array_write_en_out   (array_write_en_out),
    .array_set_addr_out   (array_set_addr_out),
    .array_way_select_out (array_way_select_out),
    .array_write_bits_out (array_write_bits_out),
    .array_read_bits_in   (array_read_bits_in)
  );

  // Valid array model: masked write, registered read; starts all-ones so the sweep is visible.
  logic [NW-1:0] mem [NS] = '{default: 4'hF};
  logic [NW-1:0] rd_q = '0;
  assign array_read_bits_in = rd_q;

  always @(posedge clk_in) begin
    if (array_access_en_out) begin
      if (array_write_en_out)
        mem[array_set_addr_out] <= (mem[array_set_addr_out] & ~array_way_select_out) |
                                   (array_write_bits_out & array_way_select_out);
      else
        rd_q <= mem[array_set_addr_out];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_in) cyc++;

  typedef struct {
    logic [NW-1:0] bits;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [NW-1:0] bits);
    exp_t e;
    e.bits = bits;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented response must match the oldest expectation and arrive on its cycle.
  always @(negedge clk_in) begin
    if (lookup_resp_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got bits %0h with no lookup outstanding (cycle %0d)",
                 lookup_resp_bits_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_bits", 32'(lookup_resp_bits_out), 32'(e.bits));
        chk("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic nxt();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [2:0] readies();
    return {inv_ready_out, fill_ready_out, lookup_ready_out};
  endfunction

  // Checks one NS-cycle sweep; optionally pulses flush at pulse_k or asserts reset at abort_k.
  task automatic sweep_check(input int pulse_k, input int abort_k);
    for (int k = 0; k < int'(NS); k++) begin
      flush_req_in = (k == pulse_k);
      if (k == abort_k) begin
        reset_in = 1'b0;
        #1;
        chk("abort_access_en", 32'(array_access_en_out), 32'd0);
        chk("abort_write_en", 32'(array_write_en_out), 32'd0);
        chk("abort_busy", 32'(init_busy_out), 32'd1);
        chk("abort_flush_done", 32'(flush_done_out), 32'd0);
        return;
      end
      @(negedge clk_in);
      chk("sweep_busy", 32'(init_busy_out), 32'd1);
      chk("sweep_access_en", 32'(array_access_en_out), 32'd1);
      chk("sweep_write_en", 32'(array_write_en_out), 32'd1);
      chk("sweep_set", 32'(array_set_addr_out), 32'(k));
      chk("sweep_way", 32'(array_way_select_out), 32'hF);
      chk("sweep_bits", 32'(array_write_bits_out), 32'h0);
      chk("sweep_readies", 32'(readies()), 32'b000);
      chk("sweep_flush_done", 32'(flush_done_out), (k == int'(NS) - 1) ? 32'd1 : 32'd0);
      nxt();
    end
    flush_req_in = 1'b0;
  endtask

  task automatic do_fill(input logic [SW-1:0] set, input logic [NW-1:0] way);
    fill_valid_in = 1'b1;
    fill_set_in   = set;
    fill_way_in   = way;
    @(negedge clk_in);
    chk("fill_readies", 32'(readies()), 32'b010);
    chk("fill_set", 32'(array_set_addr_out), 32'(set));
    chk("fill_way", 32'(array_way_select_out), 32'(way));
    chk("fill_bits", 32'(array_write_bits_out), 32'hF);
    nxt();
    fill_valid_in = 1'b0;
  endtask

  task automatic do_lookups(input logic [NW-1:0] exp_bits [NS]);
    lookup_valid_in = 1'b1;
    for (int i = 0; i < int'(NS); i++) begin
      lookup_set_in = SW'(i);
      @(negedge clk_in);
      chk("lookup_ready", 32'(lookup_ready_out), 32'd1);
      chk("lookup_write_en", 32'(array_write_en_out), 32'd0);
      chk("lookup_set", 32'(array_set_addr_out), 32'(i));
      push_exp(exp_bits[i]);
      nxt();
    end
    lookup_valid_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NW-1:0] exp_a [NS];
    logic [NW-1:0] exp_z [NS];
    exp_a = '{4'h3, 4'h1, 4'h4, 4'h8};
    exp_z = '{default: 4'h0};

    reset_in        = 1'b0;
    flush_req_in    = 1'b0;
    inv_valid_in    = 1'b1; inv_set_in    = 2'd1; inv_way_in  = 4'b0001;
    fill_valid_in   = 1'b1; fill_set_in   = 2'd1; fill_way_in = 4'b0001;
    lookup_valid_in = 1'b1; lookup_set_in = 2'd1;

    // Reset state with all requesters already asserted.
    #2;
    chk("rst_busy", 32'(init_busy_out), 32'd1);
    chk("rst_readies", 32'(readies()), 32'b000);
    chk("rst_access_en", 32'(array_access_en_out), 32'd0);
    chk("rst_write_en", 32'(array_write_en_out), 32'd0);
    chk("rst_resp_valid", 32'(lookup_resp_valid_out), 32'd0);
    chk("rst_flush_done", 32'(flush_done_out), 32'd0);
    @(posedge clk_in);
    nxt();
    reset_in = 1'b1;
    sweep_check(-1, -1);

    // Simultaneous inv / fill / lookup on set 1 way 0: one grant per cycle in priority order.
    @(negedge clk_in);
    chk("hz_busy", 32'(init_busy_out), 32'd0);
    chk("hz_inv_readies", 32'(readies()), 32'b100);
    chk("hz_inv_set", 32'(array_set_addr_out), 32'd1);
    chk("hz_inv_way", 32'(array_way_select_out), 32'b0001);
    chk("hz_inv_bits", 32'(array_write_bits_out), 32'h0);
    nxt();
    inv_valid_in = 1'b0;
    @(negedge clk_in);
    chk("hz_fill_readies", 32'(readies()), 32'b010);
    chk("hz_fill_bits", 32'(array_write_bits_out), 32'hF);
    nxt();
    fill_valid_in = 1'b0;
    @(negedge clk_in);
    chk("hz_lookup_readies", 32'(readies()), 32'b001);
    chk("hz_lookup_access", 32'({array_access_en_out, array_write_en_out}), 32'b10);
    push_exp(4'b0001);
    nxt();
    lookup_valid_in = 1'b0;

    // Fill then lookup of set 2.
    do_fill(2'd2, 4'b0100);
    lookup_valid_in = 1'b1;
    lookup_set_in   = 2'd2;
    @(negedge clk_in);
    chk("l2_ready", 32'(lookup_ready_out), 32'd1);
    push_exp(4'b0100);
    nxt();
    lookup_valid_in = 1'b0;

    // Non-one-hot mask passes through; then back-to-back lookups of every set.
    do_fill(2'd0, 4'b0011);
    do_fill(2'd3, 4'b1000);
    do_lookups(exp_a);

    // Lookup granted, then flush on the next cycle while its response is on the bus.
    lookup_valid_in = 1'b1;
    lookup_set_in   = 2'd2;
    @(negedge clk_in);
    push_exp(4'b0100);
    nxt();
    flush_req_in = 1'b1;
    @(negedge clk_in);
    chk("fl_req_readies", 32'(readies()), 32'b000);
    chk("fl_req_access", 32'(array_access_en_out), 32'd0);
    chk("fl_req_busy", 32'(init_busy_out), 32'd0);
    nxt();
    lookup_valid_in = 1'b0;
    sweep_check(1, -1);
    @(negedge clk_in);
    chk("fl_after_busy", 32'(init_busy_out), 32'd0);
    chk("fl_after_done", 32'(flush_done_out), 32'd0);
    nxt();
    @(negedge clk_in);
    chk("fl_no_second_sweep", 32'(array_access_en_out), 32'd0);
    nxt();
    do_lookups(exp_z);

    // Reset between a lookup grant and its response drops the response.
    lookup_valid_in = 1'b1;
    lookup_set_in   = 2'd3;
    @(negedge clk_in);
    chk("drop_ready", 32'(lookup_ready_out), 32'd1);
    #2;
    reset_in        = 1'b0;
    lookup_valid_in = 1'b0;
    #1;
    chk("drop_access", 32'(array_access_en_out), 32'd0);
    chk("drop_busy", 32'(init_busy_out), 32'd1);
    @(posedge clk_in);
    #1;
    chk("drop_resp_valid", 32'(lookup_resp_valid_out), 32'd0);
    nxt();
    reset_in = 1'b1;

    // Reset on sweep cycle 2, then a complete sweep from set 0.
    sweep_check(-1, 2);
    nxt();
    reset_in = 1'b1;
    sweep_check(-1, -1);
    @(negedge clk_in);
    chk("end_busy", 32'(init_busy_out), 32'd0);
    nxt();
    lookup_valid_in = 1'b1;
    lookup_set_in   = 2'd1;
    @(negedge clk_in);
    push_exp(4'b0000);
    nxt();
    lookup_valid_in = 1'b0;
    nxt();
    nxt();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/valid_array_ctrl.md
Name: valid_array_ctrl

Overview:
- Sequencer and arbiter in front of one per-set, per-way valid-bit array; grants at most one array access per cycle.
- Runs a clear-all sweep after reset and on flush request.
- Arbitrates invalidate, fill and lookup requesters into the array's single access port and returns lookup results one cycle later.
- Sits between the cache pipeline and the valid array.

Parameters:
- NUMBER_SETS, 64, sets in the array
- NUMBER_WAYS, 16, ways per set
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), set index width

Ports:
- clk_in  input  1  clock, all logic on rising edge
- reset_in  input  1  asynchronous active-low reset
- flush_req_in  input  1  request clear of every valid bit
- flush_done_out  output  1  one-cycle pulse when a sweep completes
- init_busy_out  output  1  high while any sweep is running
- inv_valid_in  input  1  invalidate request
- inv_set_in  input  SET_PTR_WIDTH_IN_BITS  invalidate set
- inv_way_in  input  NUMBER_WAYS  one-hot invalidate way
- inv_ready_out  output  1  invalidate accepted this cycle
- fill_valid_in  input  1  fill (set-valid) request
- fill_set_in  input  SET_PTR_WIDTH_IN_BITS  fill set
- fill_way_in  input  NUMBER_WAYS  one-hot fill way
- fill_ready_out  output  1  fill accepted this cycle
- lookup_valid_in  input  1  lookup request
- lookup_set_in  input  SET_PTR_WIDTH_IN_BITS  lookup set
- lookup_ready_out  output  1  lookup accepted this cycle
- lookup_resp_valid_out  output  1  lookup result valid
- lookup_resp_bits_out  output  NUMBER_WAYS  valid bits of the looked-up set
- array_access_en_out  output  1  array access strobe
- array_write_en_out  output  1  array write strobe
- array_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  array set address
- array_way_select_out  output  NUMBER_WAYS  way mask for the write
- array_write_bits_out  output  NUMBER_WAYS  per-way value to write
- array_read_bits_in  input  NUMBER_WAYS  array read data, one cycle after access

Behaviour:
- Reset (reset_in=0, asynchronous):
  - state=INIT, sweep counter=0.
  - All ready, response and array strobe outputs are 0; flush_done_out=0; init_busy_out=1.
- States:
  - INIT: sweep after reset.
  - RUN: normal arbitration.
  - FLUSH: sweep on request.
- Sweep (INIT and FLUSH):
  - Each cycle: access_en=1, write_en=1, set_addr=counter, way_select=all ones, write_bits=0.
  - Counter increments by 1. At counter=NUMBER_SETS-1 it wraps to 0, state goes to RUN and flush_done_out pulses for one cycle.
  - Sweep length is exactly NUMBER_SETS cycles.
  - All ready outputs are 0 during a sweep; init_busy_out=1.
- RUN:
  - flush_req_in=1 enters FLUSH next cycle; no request is granted that cycle.
  - A flush_req_in arriving during a sweep is absorbed; no second sweep runs.
- Priority in RUN (one grant per cycle): invalidate > fill > lookup. Ready is combinational from the valid inputs and state.
  - Invalidate grant: write_en=1, set=inv_set_in, way_select=inv_way_in, write_bits=0.
  - Fill grant: write_en=1, set=fill_set_in, way_select=fill_way_in, write_bits=all ones.
  - Lookup grant: access_en=1, write_en=0, set=lookup_set_in.
- Lookup response:
  - Registered one cycle after grant: lookup_resp_valid_out=1, lookup_resp_bits_out=array_read_bits_in.
  - Back-to-back lookups give back-to-back responses.
  - A response already issued completes even if a flush starts in the same cycle.
- Hazards:
  - Write and lookup are never granted in the same cycle, so every lookup sees all earlier writes.
  - Fill and invalidate to the same set/way in one cycle: invalidate wins; fill stays stalled (ready=0) and is granted next cycle. The final bit is 1, by arrival order at the array.
- Requesters must hold valid and payload stable until ready. A non-one-hot way mask is passed through unchanged.
- Reset during a sweep or mid-lookup returns to INIT; a pending response is dropped.

Decomposition:
- Shared package valid_ctrl_pkg: state encoding (INIT, RUN, FLUSH) and grant-source encoding (NONE, INV, FILL, LOOKUP).
- One sub-module: valid_array_sweep_counter (enable, wrap, last-pulse). The arbiter stays inline.

Test Plan:
- Reset with NUMBER_SETS=4, WAYS=4 -> init_busy_out=1 for 4 cycles, addresses 0,1,2,3 written with write_bits=0; flush_done_out pulses on the cycle set 3 is written; ready outputs 0 throughout.
- Fill set 2 way 0b0100, then lookup set 2, with array model -> lookup_resp_bits_out=0b0100 exactly one cycle after lookup grant.
- Same cycle: inv set1 way 0b0001, fill set1 way 0b0001, lookup set1 -> inv granted cycle 0, fill cycle 1, lookup cycle 2; response bits[0]=1.
- flush_req_in pulse in RUN, then again mid-sweep -> one 4-cycle sweep, one flush_done_out pulse; later lookup of any set returns 0.
- Lookups to sets 0,1,2,3 on consecutive cycles -> four consecutive responses in order, no bubbles.
- reset_in asserted on sweep cycle 2 -> outputs 0 immediately, sweep restarts at set 0 after release.
